// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM state type, forwarding
// select encodings, register-zero constant, data width and the source-match helper.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned REG_W      = 3;
    localparam int unsigned WAIT_CNT_W = 4;

    localparam logic [REG_W-1:0] REG_ZERO = 3'd0;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    typedef enum logic [0:0] {
        StRun     = 1'b0,
        StMemWait = 1'b1
    } mem_state_e;

    // Register zero is hard-wired, so it never creates a dependency.
    function automatic logic src_hit(input logic [REG_W-1:0] src,
                                     input logic             used,
                                     input logic             wb_en,
                                     input logic [REG_W-1:0] dest);
        return used && wb_en && (src == dest) && (src != REG_ZERO);
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait sequencer: RUN/MEM_WAIT FSM driving freeze_all, sticky wait timeout
// and the saturating stalled-cycle counter.
module mem_wait_fsm
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_access,
    input  logic              mem_ready,
    input  logic              stall_front,
    output logic              freeze_all,
    output logic              mem_timeout,
    output logic [DATA_W-1:0] stall_count
);

    localparam logic [WAIT_CNT_W-1:0] WaitLast = WAIT_CNT_W'(MEM_TIMEOUT - 1);

    mem_state_e            state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  timeout_q, timeout_d;
    logic                  freeze;
    logic [DATA_W-1:0]     stall_cnt_q, stall_cnt_d;

    // Once the timeout has fired the memory is treated as dead: no new freezes until
    // reset, otherwise a held access would immediately re-freeze the pipeline.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        freeze     = 1'b0;
        unique case (state_q)
            StRun: begin
                if (mem_access && !mem_ready && !timeout_q) begin
                    freeze     = 1'b1;
                    state_d    = StMemWait;
                    wait_cnt_d = '0;
                end
            end
            StMemWait: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (mem_ready) begin
                    state_d = StRun;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt_q == WaitLast) begin
                        state_d   = StRun;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    assign freeze_all  = freeze & ~reset;
    assign mem_timeout = timeout_q;
    assign stall_count = stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((stall_front || freeze_all) && (stall_cnt_q != {DATA_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use/branch control and memory freeze.
// Build option HAZARD_FWD_EN enables forwarding; without it every RAW dependency stalls.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_W-1:0]  id_src1,
    input  logic [REG_W-1:0]  id_src2,
    input  logic              id_src1_used,
    input  logic              id_src2_used,
    input  logic              ex_wb_en,
    input  logic [REG_W-1:0]  ex_dest,
    input  logic              ex_is_load,
    input  logic              mem_wb_en,
    input  logic [REG_W-1:0]  mem_dest,
    input  logic              mem_access,
    input  logic              mem_ready,
    input  logic              wb_wb_en,
    input  logic [REG_W-1:0]  wb_dest,
    input  logic              branch_taken,
    output logic [1:0]        fwd_sel1,
    output logic [1:0]        fwd_sel2,
    output logic              stall_front,
    output logic              bubble_ex,
    output logic              flush_ifid,
    output logic              freeze_all,
    output logic              mem_timeout,
    output logic [DATA_W-1:0] stall_count
);

    logic       ex_hit1, ex_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;
    logic       raw_stall;
    logic [1:0] sel1_raw, sel2_raw;
    logic       freeze;

    assign ex_hit1  = src_hit(id_src1, id_src1_used, ex_wb_en, ex_dest);
    assign ex_hit2  = src_hit(id_src2, id_src2_used, ex_wb_en, ex_dest);
    assign mem_hit1 = src_hit(id_src1, id_src1_used, mem_wb_en, mem_dest);
    assign mem_hit2 = src_hit(id_src2, id_src2_used, mem_wb_en, mem_dest);
    assign wb_hit1  = src_hit(id_src1, id_src1_used, wb_wb_en, wb_dest);
    assign wb_hit2  = src_hit(id_src2, id_src2_used, wb_wb_en, wb_dest);

`ifdef HAZARD_FWD_EN
    logic load_use;
    logic lu_stall_q, lu_stall_d;
    logic unused_wb;

    // WB results reach ID through the register file (write-before-read), so no WB path.
    assign unused_wb = wb_hit1 | wb_hit2;

    assign sel1_raw = ex_hit1 ? FWD_EXMEM : (mem_hit1 ? FWD_MEMWB : FWD_RF);
    assign sel2_raw = ex_hit2 ? FWD_EXMEM : (mem_hit2 ? FWD_MEMWB : FWD_RF);

    // A load-use stall lasts one cycle: the load has then produced its data and the
    // dependency is served by the EX/MEM path. Frozen cycles leave the one-shot untouched.
    assign load_use   = ex_is_load & (ex_hit1 | ex_hit2);
    assign raw_stall  = load_use & ~lu_stall_q;
    assign lu_stall_d = freeze ? lu_stall_q : stall_front;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lu_stall_q <= 1'b0;
        end else begin
            lu_stall_q <= lu_stall_d;
        end
    end
`else
    logic unused_load;

    assign unused_load = ex_is_load;
    assign sel1_raw    = FWD_RF;
    assign sel2_raw    = FWD_RF;
    assign raw_stall   = ex_hit1 | ex_hit2 | mem_hit1 | mem_hit2 | wb_hit1 | wb_hit2;
`endif

    // Freeze beats branch beats stall; a masked branch/hazard is re-seen after the freeze.
    always_comb begin
        fwd_sel1    = sel1_raw;
        fwd_sel2    = sel2_raw;
        stall_front = 1'b0;
        bubble_ex   = 1'b0;
        flush_ifid  = 1'b0;
        if (reset) begin
            fwd_sel1 = FWD_RF;
            fwd_sel2 = FWD_RF;
        end else if (!freeze) begin
            if (branch_taken) begin
                flush_ifid = 1'b1;
                bubble_ex  = 1'b1;
            end else if (raw_stall) begin
                stall_front = 1'b1;
                bubble_ex   = 1'b1;
            end
        end
    end

    assign freeze_all = freeze;

    mem_wait_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_fsm (
        .clock       (clock),
        .reset       (reset),
        .mem_access  (mem_access),
        .mem_ready   (mem_ready),
        .stall_front (stall_front),
        .freeze_all  (freeze),
        .mem_timeout (mem_timeout),
        .stall_count (stall_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TIMEOUT = 4;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clock, reset;
    logic [2:0]  id_src1, id_src2, ex_dest, mem_dest, wb_dest;
    logic        id_src1_used, id_src2_used, ex_wb_en, ex_is_load, mem_wb_en;
    logic        mem_access, mem_ready, wb_wb_en, branch_taken;
    logic [1:0]  fwd_sel1, fwd_sel2;
    logic        stall_front, bubble_ex, flush_ifid, freeze_all, mem_timeout;
    logic [15:0] stall_count;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model state
    bit m_in_wait;
    int m_waits;
    bit m_timed_out;
    int m_cnt;
    bit m_prev_lu;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_src1_used (id_src1_used),
        .id_src2_used (id_src2_used),
        .ex_wb_en     (ex_wb_en),
        .ex_dest      (ex_dest),
        .ex_is_load   (ex_is_load),
        .mem_wb_en    (mem_wb_en),
        .mem_dest     (mem_dest),
        .mem_access   (mem_access),
        .mem_ready    (mem_ready),
        .wb_wb_en     (wb_wb_en),
        .wb_dest      (wb_dest),
        .branch_taken (branch_taken),
        .fwd_sel1     (fwd_sel1),
        .fwd_sel2     (fwd_sel2),
        .stall_front  (stall_front),
        .bubble_ex    (bubble_ex),
        .flush_ifid   (flush_ifid),
        .freeze_all   (freeze_all),
        .mem_timeout  (mem_timeout),
        .stall_count  (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit hit(input logic [2:0] src, input logic used, input logic en,
                               input logic [2:0] dst);
        return used && en && (src == dst) && (src != 3'd0);
    endfunction

    task automatic clear_inputs();
        id_src1 = 0; id_src2 = 0; id_src1_used = 0; id_src2_used = 0;
        ex_wb_en = 0; ex_dest = 0; ex_is_load = 0;
        mem_wb_en = 0; mem_dest = 0; mem_access = 0; mem_ready = 0;
        wb_wb_en = 0; wb_dest = 0; branch_taken = 0;
    endtask

    // Sample at the falling edge, compare against the model, then advance the model.
    task automatic check_cycle();
        bit e1, e2, m1, m2, w1, w2, raw, e_frz, e_stall, e_bub, e_flush;
        logic [1:0] ef1, ef2;
        @(negedge clock);
        e1 = hit(id_src1, id_src1_used, ex_wb_en, ex_dest);
        e2 = hit(id_src2, id_src2_used, ex_wb_en, ex_dest);
        m1 = hit(id_src1, id_src1_used, mem_wb_en, mem_dest);
        m2 = hit(id_src2, id_src2_used, mem_wb_en, mem_dest);
        w1 = hit(id_src1, id_src1_used, wb_wb_en, wb_dest);
        w2 = hit(id_src2, id_src2_used, wb_wb_en, wb_dest);
        ef1 = 0; ef2 = 0; raw = 0; e_frz = 0; e_stall = 0; e_bub = 0; e_flush = 0;
        if (reset) begin
            m_in_wait = 0; m_waits = 0; m_timed_out = 0; m_cnt = 0; m_prev_lu = 0;
        end else begin
            if (FWD) begin
                ef1 = e1 ? 2'd1 : (m1 ? 2'd2 : 2'd0);
                ef2 = e2 ? 2'd1 : (m2 ? 2'd2 : 2'd0);
                raw = ex_is_load && (e1 || e2) && !m_prev_lu;
            end else begin
                raw = e1 || e2 || m1 || m2 || w1 || w2;
            end
            e_frz = !m_timed_out && !mem_ready && (m_in_wait || mem_access);
            if (!e_frz) begin
                if (branch_taken) begin
                    e_flush = 1; e_bub = 1;
                end else if (raw) begin
                    e_stall = 1; e_bub = 1;
                end
            end
        end
        check_eq("fwd_sel1", 32'(fwd_sel1), 32'(ef1));
        check_eq("fwd_sel2", 32'(fwd_sel2), 32'(ef2));
        check_eq("stall_front", 32'(stall_front), 32'(e_stall));
        check_eq("bubble_ex", 32'(bubble_ex), 32'(e_bub));
        check_eq("flush_ifid", 32'(flush_ifid), 32'(e_flush));
        check_eq("freeze_all", 32'(freeze_all), 32'(e_frz));
        check_eq("mem_timeout", 32'(mem_timeout), 32'(m_timed_out));
        check_eq("stall_count", 32'(stall_count), 32'(m_cnt));
        if (!reset) begin
            if (m_in_wait) begin
                m_waits++;
                if (mem_ready) m_in_wait = 0;
                else if (m_waits == int'(TIMEOUT)) begin
                    m_timed_out = 1;
                    m_in_wait   = 0;
                end
            end else if (e_frz) begin
                m_in_wait = 1;
                m_waits   = 0;
            end
            if (!e_frz) m_prev_lu = e_stall;
            if ((e_stall || e_frz) && m_cnt < 65535) m_cnt++;
        end
    endtask

    task automatic advance();
        @(posedge clock);
        #1;
    endtask

    initial begin
        clear_inputs();
        m_in_wait = 0; m_waits = 0; m_timed_out = 0; m_cnt = 0; m_prev_lu = 0;

        // Reset with hazard, branch and memory stimulus all active
        reset = 1;
        ex_wb_en = 1; ex_dest = 3; id_src1 = 3; id_src1_used = 1;
        branch_taken = 1; mem_access = 1;
        check_cycle();
        check_eq("rst_fwd1", 32'(fwd_sel1), 0);
        check_eq("rst_flush", 32'(flush_ifid), 0);
        check_eq("rst_freeze", 32'(freeze_all), 0);
        advance();
        reset = 0;
        clear_inputs();

        // Forward from EX/MEM
        ex_wb_en = 1; ex_dest = 3; id_src1 = 3; id_src1_used = 1;
        check_cycle();
        check_eq("fwd_ex_sel1", 32'(fwd_sel1), FWD ? 1 : 0);
        check_eq("fwd_ex_stall", 32'(stall_front), FWD ? 0 : 1);
        advance();

        // Load-use: one stall cycle, then EX forwarding
        clear_inputs();
        ex_is_load = 1; ex_wb_en = 1; ex_dest = 5; id_src2 = 5; id_src2_used = 1;
        check_cycle();
        check_eq("lu_stall", 32'(stall_front), 1);
        check_eq("lu_bubble", 32'(bubble_ex), 1);
        advance();
        check_cycle();
        check_eq("lu_after_stall", 32'(stall_front), FWD ? 0 : 1);
        check_eq("lu_after_sel2", 32'(fwd_sel2), FWD ? 1 : 0);
        advance();

        // Branch overrides load-use
        branch_taken = 1;
        check_cycle();
        check_eq("br_flush", 32'(flush_ifid), 1);
        check_eq("br_bubble", 32'(bubble_ex), 1);
        check_eq("br_stall", 32'(stall_front), 0);
        advance();

        // Memory wait: ready low 3 cycles then high
        clear_inputs();
        reset = 1;
        check_cycle();
        advance();
        reset = 0;
        mem_access = 1;
        for (int i = 0; i < 3; i++) begin
            check_cycle();
            check_eq("mw_freeze", 32'(freeze_all), 1);
            advance();
        end
        mem_ready = 1;
        check_cycle();
        check_eq("mw_ready_freeze", 32'(freeze_all), 0);
        advance();
        clear_inputs();
        check_cycle();
        check_eq("mw_stall_count", 32'(stall_count), 3);
        advance();

        // Timeout: ready held low
        mem_access = 1;
        for (int i = 0; i < 5; i++) begin
            check_cycle();
            check_eq("to_freeze", 32'(freeze_all), 1);
            check_eq("to_not_yet", 32'(mem_timeout), 0);
            advance();
        end
        for (int i = 0; i < 2; i++) begin
            check_cycle();
            check_eq("to_set", 32'(mem_timeout), 1);
            check_eq("to_released", 32'(freeze_all), 0);
            advance();
        end
        check_eq("to_stall_count", 32'(stall_count), 8);

        // Reset in the middle of a memory wait, then register-zero check
        clear_inputs();
        reset = 1;
        check_cycle();
        advance();
        reset = 0;
        mem_access = 1;
        check_cycle();
        advance();
        check_cycle();
        check_eq("mr_waiting", 32'(freeze_all), 1);
        @(posedge clock);
        #2;
        reset = 1;
        check_cycle();
        check_eq("mr_freeze", 32'(freeze_all), 0);
        check_eq("mr_count", 32'(stall_count), 0);
        advance();
        reset = 0;
        clear_inputs();
        check_cycle();
        check_eq("mr_no_residual", 32'(freeze_all), 0);
        advance();
        ex_wb_en = 1; ex_dest = 0; id_src1 = 0; id_src1_used = 1;
        mem_wb_en = 1; wb_wb_en = 1;
        check_cycle();
        check_eq("r0_sel1", 32'(fwd_sel1), 0);
        check_eq("r0_stall", 32'(stall_front), 0);
        advance();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom_range(0, 59) == 0);
            id_src1      = 3'($urandom_range(0, 3));
            id_src2      = 3'($urandom_range(0, 3));
            id_src1_used = 1'($urandom_range(0, 1));
            id_src2_used = 1'($urandom_range(0, 1));
            ex_wb_en     = 1'($urandom_range(0, 1));
            ex_dest      = 3'($urandom_range(0, 3));
            ex_is_load   = 1'($urandom_range(0, 1));
            mem_wb_en    = 1'($urandom_range(0, 1));
            mem_dest     = 3'($urandom_range(0, 3));
            wb_wb_en     = 1'($urandom_range(0, 1));
            wb_dest      = 3'($urandom_range(0, 3));
            branch_taken = ($urandom_range(0, 7) == 0);
            mem_access   = ($urandom_range(0, 3) == 0);
            mem_ready    = ($urandom_range(0, 2) == 0);
            check_cycle();
            advance();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
